// File: rtl/mac_dot_seq_if.sv
// +----------------------------------------------------------------------+
// | mac_dot_seq_if : operand-pair valid/ready stream into the sequencer  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface mac_dot_seq_if #(
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input  in_ready);
  modport slave  (input  in_valid, input  in_a, input  in_b, output in_ready);
endinterface

`default_nettype wire

// File: rtl/mac_dot_seq.sv
// +----------------------------------------------------------------------+
// | mac_dot_seq : dot-product sequencer driving a 64-bit accumulating MAC |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mac_dot_seq #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int LEN_W  = 16
) (
  input  wire logic              clock,
  input  wire logic              reset_n,
  input  wire logic              start,
  input  wire logic [LEN_W-1:0]  len,
  input  wire logic              sub_mode,
  mac_dot_seq_if.slave           in_if,
  output logic [DATA_W-1:0]      mac_M,
  output logic [DATA_W-1:0]      mac_N,
  output logic                   mac_en,
  output logic [2:0]             mac_op,
  input  wire logic [DATA_W-1:0] mac_out,
  output logic                   busy,
  output logic                   done,
  output logic [ACC_W-1:0]       result
);

  localparam logic [1:0] OP_MAC  = 2'd0;
  localparam logic [1:0] OP_MTA  = 2'd1;
  localparam logic [1:0] OP_MTAN = 2'd2;
  localparam logic [1:0] OP_MSC  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIRST = 3'd1,
    S_ACC   = 3'd2,
    S_CLR   = 3'd3,
    S_RD_LO = 3'd4,
    S_RD_HI = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             sub_r;
  logic             xfer;

  assign xfer = in_if.in_valid && in_if.in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      sub_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= len;
            sub_r     <= sub_mode;
            busy      <= 1'b1;
            state     <= (len != '0) ? S_FIRST : S_CLR;
          end
        end
        S_FIRST, S_ACC: begin
          if (xfer) begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              state <= S_RD_LO;
            end else begin
              state <= S_ACC;
            end
          end
        end
        S_CLR: begin
          state <= S_RD_LO;
        end
        S_RD_LO: begin
          result[DATA_W-1:0] <= mac_out;
          state              <= S_RD_HI;
        end
        S_RD_HI: begin
          result[ACC_W-1:DATA_W] <= mac_out;
          done                   <= 1'b1;
          state                  <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // MAC drive is decoded from state so operands reach the MAC in the transfer cycle
  always_comb begin
    in_if.in_ready = 1'b0;
    mac_M          = '0;
    mac_N          = '0;
    mac_en         = 1'b0;
    mac_op         = 3'b000;
    case (state)
      S_FIRST: begin
        in_if.in_ready = 1'b1;
        mac_M          = in_if.in_a;
        mac_N          = in_if.in_b;
        mac_en         = in_if.in_valid;
        mac_op         = {1'b0, sub_r ? OP_MTAN : OP_MTA};
      end
      S_ACC: begin
        in_if.in_ready = 1'b1;
        mac_M          = in_if.in_a;
        mac_N          = in_if.in_b;
        mac_en         = in_if.in_valid;
        mac_op         = {1'b0, sub_r ? OP_MSC : OP_MAC};
      end
      S_CLR: begin
        mac_en = 1'b1;
        mac_op = {1'b0, OP_MTA};
      end
      S_RD_HI: begin
        mac_op = 3'b100;
      end
      default: begin
        mac_op = 3'b000;
      end
    endcase
  end

endmodule

`default_nettype wire
